// File: rtl/z_result_unloader_if.sv
// z_result_unloader_if: word-wide valid/ready beat bus from the Z result register to the datapath
interface z_result_unloader_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_is_high;

    modport master (
        output out_data,
        output out_valid,
        output out_is_high,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  out_is_high,
        output out_ready
    );
endinterface

// File: rtl/z_result_unloader.sv
// z_result_unloader: captures a double-width ALU result into Z and drains it as low then optional high beat
module z_result_unloader #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clock,
    input  logic                    clear,
    input  logic [2*DATA_WIDTH-1:0] result_in,
    input  logic                    capture,
    input  logic                    lo_only,
    input  logic                    overrun_clr,
    output logic                    hi_nonzero,
    output logic                    busy,
    output logic                    overrun,
    z_result_unloader_if.master     bus
);
    typedef enum logic [1:0] {IDLE, SEND_LO, SEND_HI} state_t;

    state_t                  state;
    logic [2*DATA_WIDTH-1:0] z;
    logic                    lo_only_r;
    logic                    final_beat;
    logic                    accept;

    // A new capture may ride on the handshake of the last beat so streams have no bubble
    assign final_beat = bus.out_ready && ((state == SEND_LO && lo_only_r) || state == SEND_HI);
    assign accept     = capture && (state == IDLE || final_beat);

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state      <= IDLE;
            z          <= '0;
            lo_only_r  <= 1'b0;
            hi_nonzero <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (accept) begin
                z          <= result_in;
                lo_only_r  <= lo_only;
                hi_nonzero <= |result_in[2*DATA_WIDTH-1:DATA_WIDTH];
                state      <= SEND_LO;
            end else if (bus.out_ready) begin
                state <= (state == SEND_LO && !lo_only_r) ? SEND_HI : IDLE;
            end
            // A dropped capture beats a simultaneous clear request
            overrun <= (capture && !accept) ? 1'b1 : overrun_clr ? 1'b0 : overrun;
        end
    end

    always_comb begin
        bus.out_data = (state == SEND_LO) ? z[DATA_WIDTH-1:0] :
                       (state == SEND_HI) ? z[2*DATA_WIDTH-1:DATA_WIDTH] : '0;
    end

    assign bus.out_valid   = (state != IDLE);
    assign bus.out_is_high = (state == SEND_HI);
    assign busy            = (state != IDLE);
endmodule

// File: tb/tb_z_result_unloader.sv
// tb_z_result_unloader: directed stimulus with a beat scoreboard checked by an independent monitor
module tb_z_result_unloader;
    localparam int W = 32;

    typedef struct {
        logic [W-1:0] d;
        logic         h;
        logic         hn;
    } beat_t;

    logic           clock = 1'b0;
    logic           clear = 1'b1;
    logic [2*W-1:0] result_in = '0;
    logic           capture = 1'b0;
    logic           lo_only = 1'b0;
    logic           overrun_clr = 1'b0;
    logic           hi_nonzero;
    logic           busy;
    logic           overrun;
    int             n_chk = 0;
    int             n_fail = 0;
    beat_t          q[$];

    z_result_unloader_if #(.DATA_WIDTH(W)) bus ();

    z_result_unloader #(.DATA_WIDTH(W)) dut (
        .clock      (clock),
        .clear      (clear),
        .result_in  (result_in),
        .capture    (capture),
        .lo_only    (lo_only),
        .overrun_clr(overrun_clr),
        .hi_nonzero (hi_nonzero),
        .busy       (busy),
        .overrun    (overrun),
        .bus        (bus)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Issue a capture and queue the beats it should produce
    task automatic cap(input logic [2*W-1:0] r, input logic lo, input logic expect_hi);
        beat_t b;
        result_in = r;
        lo_only   = lo;
        capture   = 1'b1;
        b.d  = r[W-1:0];
        b.h  = 1'b0;
        b.hn = |r[2*W-1:W];
        q.push_back(b);
        if (!lo && expect_hi) begin
            b.d = r[2*W-1:W];
            b.h = 1'b1;
            q.push_back(b);
        end
    endtask

    always @(negedge clock) begin
        if (!clear && bus.out_valid && bus.out_ready) begin
            if (q.size() == 0) begin
                chk("unexpected_beat", {32'd0, bus.out_data}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                beat_t e;
                e = q.pop_front();
                chk("beat_data", {32'd0, bus.out_data}, {32'd0, e.d});
                chk("beat_is_high", {63'd0, bus.out_is_high}, {63'd0, e.h});
                chk("beat_hi_nonzero", {63'd0, hi_nonzero}, {63'd0, e.hn});
                chk("beat_busy", {63'd0, busy}, 64'd1);
            end
        end
    end

    initial begin
        bus.out_ready = 1'b0;
        #1;
        chk("rst_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_data", {32'd0, bus.out_data}, 64'd0);
        chk("rst_is_high", {63'd0, bus.out_is_high}, 64'd0);
        chk("rst_overrun", {63'd0, overrun}, 64'd0);
        chk("rst_hi_nonzero", {63'd0, hi_nonzero}, 64'd0);
        step();
        step();
        clear = 1'b0;
        step();

        // Two-beat unload
        bus.out_ready = 1'b1;
        cap(64'h0000_0003_FFFF_0000, 1'b0, 1'b1);
        step();
        capture = 1'b0;
        chk("t1_lo_data", {32'd0, bus.out_data}, 64'hFFFF_0000);
        step();
        chk("t1_hi_flag", {63'd0, bus.out_is_high}, 64'd1);
        step();
        chk("t1_idle_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("t1_idle_busy", {63'd0, busy}, 64'd0);

        // Single low beat for a logical op
        cap(64'h0000_0000_0000_000F, 1'b1, 1'b0);
        step();
        capture = 1'b0;
        chk("t2_hi_nonzero", {63'd0, hi_nonzero}, 64'd0);
        step();
        chk("t2_idle_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("t2_idle_is_high", {63'd0, bus.out_is_high}, 64'd0);

        // Backpressure holds the low word
        bus.out_ready = 1'b0;
        cap(64'hAAAA_AAAA_1234_5678, 1'b0, 1'b1);
        step();
        capture = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("t3_hold_data", {32'd0, bus.out_data}, 64'h1234_5678);
            chk("t3_hold_is_high", {63'd0, bus.out_is_high}, 64'd0);
            step();
        end
        bus.out_ready = 1'b1;
        chk("t3_hold_data_last", {32'd0, bus.out_data}, 64'h1234_5678);
        step();
        chk("t3_hi_data", {32'd0, bus.out_data}, 64'hAAAA_AAAA);
        step();
        chk("t3_idle_valid", {63'd0, bus.out_valid}, 64'd0);

        // Overrun: second capture during a stalled low beat is dropped
        bus.out_ready = 1'b0;
        cap(64'h1111_1111_2222_2222, 1'b0, 1'b1);
        step();
        result_in = 64'h3333_3333_4444_4444;
        capture = 1'b1;
        step();
        capture = 1'b0;
        chk("t4_overrun_set", {63'd0, overrun}, 64'd1);
        chk("t4_data_kept", {32'd0, bus.out_data}, 64'h2222_2222);
        bus.out_ready = 1'b1;
        step();
        step();
        chk("t4_idle_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("t4_overrun_sticky", {63'd0, overrun}, 64'd1);
        overrun_clr = 1'b1;
        step();
        overrun_clr = 1'b0;
        chk("t4_overrun_clr", {63'd0, overrun}, 64'd0);

        // Set beats clear in the same cycle
        bus.out_ready = 1'b0;
        cap(64'h0000_0000_0000_00C3, 1'b1, 1'b0);
        step();
        result_in = 64'h0000_0000_0000_00D4;
        overrun_clr = 1'b1;
        step();
        capture = 1'b0;
        chk("t4_set_wins", {63'd0, overrun}, 64'd1);
        step();
        overrun_clr = 1'b0;
        chk("t4_clr_again", {63'd0, overrun}, 64'd0);
        bus.out_ready = 1'b1;
        step();
        chk("t4b_idle_valid", {63'd0, bus.out_valid}, 64'd0);

        // Back-to-back single beats with no bubble
        cap(64'h0000_0000_0000_00AA, 1'b1, 1'b0);
        step();
        cap(64'h0000_0000_0000_0055, 1'b1, 1'b0);
        step();
        capture = 1'b0;
        chk("t5_valid_cont", {63'd0, bus.out_valid}, 64'd1);
        chk("t5_b_data", {32'd0, bus.out_data}, 64'h55);
        step();
        chk("t5_idle_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("t5_no_overrun", {63'd0, overrun}, 64'd0);

        // Asynchronous clear in the middle of the high beat
        cap(64'hDEAD_BEEF_CAFE_F00D, 1'b0, 1'b0);
        step();
        capture = 1'b0;
        step();
        chk("t6_in_hi", {63'd0, bus.out_is_high}, 64'd1);
        #2;
        clear = 1'b1;
        #1;
        chk("t6_clr_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("t6_clr_busy", {63'd0, busy}, 64'd0);
        chk("t6_clr_data", {32'd0, bus.out_data}, 64'd0);
        chk("t6_clr_hi_nonzero", {63'd0, hi_nonzero}, 64'd0);
        #3;
        clear = 1'b0;
        step();
        step();
        chk("t6_stay_idle_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("t6_stay_idle_busy", {63'd0, busy}, 64'd0);
        cap(64'h0000_0000_0000_0077, 1'b1, 1'b0);
        step();
        capture = 1'b0;
        chk("t6_restart_data", {32'd0, bus.out_data}, 64'h77);
        step();
        step();
        chk("queue_drained", 64'(q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
